// File: rtl/ddr3_iod_dly_pkg.sv
// Shared definitions for the DDR3 address/command IOD delay controller:
// FSM state encoding, default parameter values and field widths.
package ddr3_iod_dly_pkg;

    localparam int NUM_LANES_DEF = 15;
    localparam int MOVE_GAP_DEF  = 3;
    localparam int MAX_TAP_DEF   = 127;
    localparam int LOAD_TAP_DEF  = 1;

    localparam int LANE_W = 4;
    localparam int TAP_W  = 7;
    localparam int STEP_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_MOVE,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ddr3_iod_dly_ctrl_if.sv
// Request/completion handshake between a training engine and the delay controller.
interface ddr3_iod_dly_ctrl_if;
    import ddr3_iod_dly_pkg::*;

    logic              REQ_VALID;
    logic              REQ_READY;
    logic [LANE_W-1:0] REQ_LANE;
    logic              REQ_LOAD;
    logic              REQ_DIR;
    logic [STEP_W-1:0] REQ_STEPS;
    logic              DONE;
    logic              ERR;

    modport master (
        output REQ_VALID, REQ_LANE, REQ_LOAD, REQ_DIR, REQ_STEPS,
        input  REQ_READY, DONE, ERR
    );

    modport slave (
        input  REQ_VALID, REQ_LANE, REQ_LOAD, REQ_DIR, REQ_STEPS,
        output REQ_READY, DONE, ERR
    );

endinterface

// File: rtl/ddr3_iod_dly_tap_tracker.sv
// Per-lane shadow of the IOD tap position with load/step updates and
// saturation flags for the current tap and the tap after one more step.
module ddr3_iod_dly_tap_tracker
    import ddr3_iod_dly_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int MAX_TAP   = MAX_TAP_DEF,
    parameter int LOAD_TAP  = LOAD_TAP_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_dir,
    input  logic              i_step,
    input  logic              i_load,
    input  logic [LANE_W-1:0] i_rd_lane,
    output logic              o_sat,
    output logic              o_sat_next,
    output logic [TAP_W-1:0]  o_rd_val
);

    logic [TAP_W-1:0] r_tap [NUM_LANES];
    logic [TAP_W-1:0] w_cur;

    // Out-of-range lane indices select nothing and read back as 0.
    always_comb begin
        w_cur    = '0;
        o_rd_val = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (i_lane == LANE_W'(i))
                w_cur = r_tap[i];
            if (i_rd_lane == LANE_W'(i))
                o_rd_val = r_tap[i];
        end
    end

    assign o_sat      = i_dir ? (w_cur == TAP_W'(MAX_TAP))     : (w_cur == '0);
    assign o_sat_next = i_dir ? (w_cur == TAP_W'(MAX_TAP - 1)) : (w_cur == TAP_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_LANES; i++)
                r_tap[i] <= TAP_W'(LOAD_TAP);
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (i_lane == LANE_W'(i)) begin
                    if (i_load)
                        r_tap[i] <= TAP_W'(LOAD_TAP);
                    else if (i_step)
                        r_tap[i] <= i_dir ? r_tap[i] + 1'b1 : r_tap[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr3_iod_dly_ctrl.sv
// Sequences LOAD / MOVE strobes to the address/command IOD delay lines.
// Define DDR3_IOD_DLY_TAP_TRACK_EN to add per-lane tap tracking and saturation stops.
module ddr3_iod_dly_ctrl
    import ddr3_iod_dly_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int MOVE_GAP  = MOVE_GAP_DEF,
    parameter int MAX_TAP   = MAX_TAP_DEF,
    parameter int LOAD_TAP  = LOAD_TAP_DEF
) (
    input  logic                 FAB_CLK,
    input  logic                 SYNC_RST,
    ddr3_iod_dly_ctrl_if.slave   req_if,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE,
    input  logic [LANE_W-1:0]    TAP_RD_LANE,
    output logic [TAP_W-1:0]     TAP_RD_VAL
);

    localparam logic [LANE_W:0] LANE_LIM = (LANE_W + 1)'(NUM_LANES);

    state_t              r_state;
    state_t              w_next;
    logic [LANE_W-1:0]   r_lane;
    logic                r_dir;
    logic [STEP_W-1:0]   r_steps;
    logic [7:0]          r_gap;
    logic                r_err;

    logic                w_ready;
    logic                w_accept;
    logic                w_in_lane_ok;
    logic                w_oor;
    logic                w_step;
    logic                w_err_set;
    logic                w_sat;
    logic                w_sat_next;
    logic [NUM_LANES-1:0] w_lane_oh;

    assign w_ready      = (r_state == ST_IDLE) && !SYNC_RST;
    assign w_accept     = req_if.REQ_VALID && w_ready;
    assign w_in_lane_ok = {1'b0, req_if.REQ_LANE} < LANE_LIM;

    always_comb begin
        w_lane_oh = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++)
            w_lane_oh[i] = (r_lane == LANE_W'(i));
    end

    assign w_oor = |(DELAY_LINE_OUT_OF_RANGE & w_lane_oh);

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        w_step    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_in_lane_ok) begin
                        w_next    = ST_DONE;
                        w_err_set = 1'b1;
                    end else if (req_if.REQ_LOAD)
                        w_next = ST_LOAD;
                    else if (req_if.REQ_STEPS == '0)
                        w_next = ST_DONE;
                    else
                        w_next = ST_SETUP;
                end
            end
            ST_LOAD:  w_next = ST_DONE;
            ST_SETUP: begin
                if (w_sat) begin
                    w_next    = ST_DONE;
                    w_err_set = 1'b1;
                end else
                    w_next = ST_MOVE;
            end
            ST_MOVE:  w_next = ST_GAP;
            ST_GAP: begin
                // The tap moves on the last gap cycle; a saturated post-step tap
                // stops here so no further MOVE is pulsed.
                if (r_gap == '0) begin
                    if (w_oor) begin
                        w_next    = ST_DONE;
                        w_err_set = 1'b1;
                    end else begin
                        w_step = 1'b1;
                        if (r_steps == STEP_W'(1))
                            w_next = ST_DONE;
                        else if (w_sat_next) begin
                            w_next    = ST_DONE;
                            w_err_set = 1'b1;
                        end else
                            w_next = ST_MOVE;
                    end
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_state <= ST_IDLE;
            r_lane  <= '0;
            r_dir   <= 1'b0;
            r_steps <= '0;
            r_gap   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_lane  <= req_if.REQ_LANE;
                r_dir   <= req_if.REQ_DIR;
                r_steps <= req_if.REQ_STEPS;
                r_err   <= w_err_set;
            end else if (w_err_set)
                r_err <= 1'b1;
            if (r_state == ST_MOVE)
                r_gap <= 8'(MOVE_GAP - 1);
            else if (r_state == ST_GAP && r_gap != '0)
                r_gap <= r_gap - 1'b1;
            if (w_step)
                r_steps <= r_steps - 1'b1;
        end
    end

    assign req_if.REQ_READY = w_ready;
    assign req_if.DONE      = (r_state == ST_DONE) && !SYNC_RST;
    assign req_if.ERR       = r_err && !SYNC_RST;

    assign DELAY_LINE_MOVE      = (r_state == ST_MOVE && !SYNC_RST) ? w_lane_oh : '0;
    assign DELAY_LINE_LOAD      = (r_state == ST_LOAD && !SYNC_RST) ? w_lane_oh : '0;
    assign DELAY_LINE_DIRECTION = ((r_state == ST_SETUP || r_state == ST_MOVE || r_state == ST_GAP)
                                   && r_dir && !SYNC_RST) ? w_lane_oh : '0;

`ifdef DDR3_IOD_DLY_TAP_TRACK_EN
    ddr3_iod_dly_tap_tracker #(
        .NUM_LANES (NUM_LANES),
        .MAX_TAP   (MAX_TAP),
        .LOAD_TAP  (LOAD_TAP)
    ) u_tap_tracker (
        .i_clk      (FAB_CLK),
        .i_rst      (SYNC_RST),
        .i_lane     (r_lane),
        .i_dir      (r_dir),
        .i_step     (w_step),
        .i_load     (r_state == ST_LOAD),
        .i_rd_lane  (TAP_RD_LANE),
        .o_sat      (w_sat),
        .o_sat_next (w_sat_next),
        .o_rd_val   (TAP_RD_VAL)
    );
`else
    logic w_unused;
    assign w_unused   = ^{TAP_RD_LANE, TAP_W'(MAX_TAP), TAP_W'(LOAD_TAP)};
    assign w_sat      = 1'b0;
    assign w_sat_next = 1'b0;
    assign TAP_RD_VAL = '0;
`endif

endmodule

// File: tb/tb_ddr3_iod_dly_ctrl.sv
// Scoreboard bench for ddr3_iod_dly_ctrl: directed requests push expected
// completions; a negedge monitor records strobes and checks each DONE.
module tb_ddr3_iod_dly_ctrl;
    import ddr3_iod_dly_pkg::*;

    localparam int NL = 15;
`ifdef DDR3_IOD_DLY_TAP_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    localparam logic [63:0] B1  = 64'd1 << 1;
    localparam logic [63:0] B2  = 64'd1 << 2;
    localparam logic [63:0] B6  = 64'd1 << 6;
    localparam logic [63:0] B10 = 64'd1 << 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NL-1:0] mv, dr, ld, oor;
    logic [3:0]    rd_lane;
    logic [6:0]    rd_val;

    always #5 clk = ~clk;

    ddr3_iod_dly_ctrl_if req_if();

    ddr3_iod_dly_ctrl #(
        .NUM_LANES (NL),
        .MOVE_GAP  (3),
        .MAX_TAP   (127),
        .LOAD_TAP  (1)
    ) dut (
        .FAB_CLK                 (clk),
        .SYNC_RST                (rst),
        .req_if                  (req_if),
        .DELAY_LINE_MOVE         (mv),
        .DELAY_LINE_DIRECTION    (dr),
        .DELAY_LINE_LOAD         (ld),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .TAP_RD_LANE             (rd_lane),
        .TAP_RD_VAL              (rd_val)
    );

    typedef struct {
        logic [3:0]  lane;
        int          done_off;
        logic        err;
        logic [63:0] mmask;
        logic [63:0] lmask;
        logic [6:0]  tap;
        logic        abort;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [3:0] lane, input int done_off, input logic err,
                                input logic [63:0] mmask, input logic [63:0] lmask,
                                input logic [6:0] tap, input logic abort);
        exp_t e;
        e.lane = lane; e.done_off = done_off; e.err = err; e.mmask = mmask;
        e.lmask = lmask; e.tap = tap; e.abort = abort;
        return e;
    endfunction

    function automatic logic [6:0] T(input logic [6:0] v);
        return TRACK ? v : 7'd0;
    endfunction

    // Monitor
    bit            active = 1'b0;
    int            cyc = 0;
    int            t0 = 0;
    exp_t          cur;
    logic [63:0]   mm, lm;
    bit            stray;

    always @(negedge clk) begin
        logic [NL-1:0] oh;
        int off;
        cyc++;
        if (rst) begin
            if (active) begin
                chk("abort_expected", cur.abort, 1'b1);
                void'(sb.pop_front());
                active = 1'b0;
            end
        end else if (req_if.REQ_VALID && req_if.REQ_READY) begin
            chk("accept_has_expectation", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                active = 1'b1; t0 = cyc; cur = sb[0];
                mm = '0; lm = '0; stray = 1'b0;
            end
        end else begin
            if (req_if.DONE && !active) begin
                n_chk++;
                $display("FAIL done_without_request: DONE=1 with no request outstanding");
            end
            if (active) begin
                off = cyc - t0;
                oh  = (cur.lane < 4'(NL)) ? (NL'(1) << cur.lane) : '0;
                if (off < 64) begin
                    mm[off] = |(mv & oh);
                    lm[off] = |(ld & oh);
                end
                if (((mv | ld | dr) & ~oh) != '0 || $countones(mv | ld) > 1) stray = 1'b1;
                if (req_if.DONE) begin
                    chk("done_cycle",   64'(off), 64'(cur.done_off));
                    chk("err",          req_if.ERR, cur.err);
                    chk("move_cycles",  mm, cur.mmask);
                    chk("load_cycles",  lm, cur.lmask);
                    chk("stray_strobe", stray, 1'b0);
                    chk("tap_readback", rd_val, cur.tap);
                    chk("not_aborted",  cur.abort, 1'b0);
                    void'(sb.pop_front());
                    active = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_if.REQ_READY && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_within_budget", req_if.REQ_READY, 1'b1);
    endtask

    task automatic issue(input logic [3:0] lane, input logic load, input logic dir,
                         input logic [6:0] steps, input exp_t e);
        wait_ready();
        sb.push_back(e);
        rd_lane           = lane;
        req_if.REQ_LANE   = lane;
        req_if.REQ_LOAD   = load;
        req_if.REQ_DIR    = dir;
        req_if.REQ_STEPS  = steps;
        req_if.REQ_VALID  = 1'b1;
        @(posedge clk); #1;
        req_if.REQ_VALID  = 1'b0;
    endtask

    initial begin
        req_if.REQ_VALID = 1'b0; req_if.REQ_LANE = '0; req_if.REQ_LOAD = 1'b0;
        req_if.REQ_DIR = 1'b0; req_if.REQ_STEPS = '0;
        oor = '0; rd_lane = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_if.REQ_READY, 1'b0);
        chk("rst_done",  req_if.DONE, 1'b0);
        chk("rst_err",   req_if.ERR, 1'b0);
        chk("rst_strobes", 64'(mv | dr | ld), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", req_if.REQ_READY, 1'b1);
        rd_lane = 4'd7;
        #1;
        chk("reset_tap", rd_val, T(7'd1));

        issue(4'd5, 1'b0, 1'b1, 7'd3, mk(4'd5, 14, 1'b0, B2 | B6 | B10, '0, T(7'd4), 1'b0));
        wait_ready();
        issue(4'd2, 1'b0, 1'b1, 7'd2, mk(4'd2, 10, 1'b0, B2 | B6, '0, T(7'd3), 1'b0));
        wait_ready();
        issue(4'd2, 1'b1, 1'b0, 7'd9, mk(4'd2, 2, 1'b0, '0, B1, T(7'd1), 1'b0));
        wait_ready();

        issue(4'd0, 1'b0, 1'b1, 7'd5, mk(4'd0, 10, 1'b1, B2 | B6, '0, T(7'd2), 1'b0));
        repeat (6) @(posedge clk);
        #1 oor[0] = 1'b1;
        wait_ready();
        oor = '0;
        chk("err_held_in_idle", req_if.ERR, 1'b1);

        issue(4'd15, 1'b0, 1'b1, 7'd3, mk(4'd15, 1, 1'b1, '0, '0, 7'd0, 1'b0));
        wait_ready();
        issue(4'd3, 1'b0, 1'b1, 7'd0, mk(4'd3, 1, 1'b0, '0, '0, T(7'd1), 1'b0));
        wait_ready();

        if (TRACK) begin
            issue(4'd1, 1'b0, 1'b0, 7'd3, mk(4'd1, 6, 1'b1, B2, '0, 7'd0, 1'b0));
            wait_ready();
            issue(4'd1, 1'b0, 1'b0, 7'd1, mk(4'd1, 2, 1'b1, '0, '0, 7'd0, 1'b0));
        end else begin
            issue(4'd1, 1'b0, 1'b0, 7'd3, mk(4'd1, 14, 1'b0, B2 | B6 | B10, '0, 7'd0, 1'b0));
            wait_ready();
            issue(4'd1, 1'b0, 1'b0, 7'd1, mk(4'd1, 6, 1'b0, B2, '0, 7'd0, 1'b0));
        end
        wait_ready();

        issue(4'd4, 1'b0, 1'b1, 7'd3, mk(4'd4, 0, 1'b0, '0, '0, 7'd0, 1'b1));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_ready", req_if.REQ_READY, 1'b0);
        chk("rst_mid_strobes", 64'(mv | dr | ld), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_strobes", 64'(mv | dr | ld), 0);
        chk("post_rst_done", req_if.DONE, 1'b0);
        chk("post_rst_err", req_if.ERR, 1'b0);
        chk("post_rst_ready", req_if.REQ_READY, 1'b1);
        rd_lane = 4'd5;
        #1;
        chk("post_rst_tap5", rd_val, T(7'd1));

        issue(4'd5, 1'b0, 1'b1, 7'd1, mk(4'd5, 6, 1'b0, B2, '0, T(7'd2), 1'b0));
        wait_ready();
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 0);
        chk("monitor_idle", active, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr3_iod_dly_ctrl.md
DDR3_IOD_DLY_CTRL -- requirements
Module: ddr3_iod_dly_ctrl

Interface
REQ-001 SHALL have parameter NUM_LANES, default 15, meaning the number of address/command IOD lanes controlled.
REQ-002 SHALL have parameter MOVE_GAP, default 3, meaning idle cycles after each DELAY_LINE_MOVE pulse before the next action.
REQ-003 SHALL have parameter MAX_TAP, default 127, meaning the highest legal tap index (7-bit).
REQ-004 SHALL have parameter LOAD_TAP, default 1, meaning the tap value restored by a LOAD (matches the IOD TX_DELAY_VAL).
REQ-005 SHALL have port FAB_CLK, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port SYNC_RST, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port REQ_VALID, input, 1 bit, request present.
REQ-008 SHALL have port REQ_READY, output, 1 bit, controller can accept.
REQ-009 SHALL have port REQ_LANE, input, 4 bits, target lane index.
REQ-010 SHALL have ports REQ_LOAD and REQ_DIR, inputs, 1 bit each: load request; direction (1 = increase delay).
REQ-011 SHALL have port REQ_STEPS, input, 7 bits, number of tap moves.
REQ-012 SHALL have ports DONE and ERR, outputs, 1 bit each: completion pulse; error flag.
REQ-013 SHALL have ports DELAY_LINE_MOVE, DELAY_LINE_DIRECTION and DELAY_LINE_LOAD, outputs, NUM_LANES bits each, per-lane IOD controls.
REQ-014 SHALL have port DELAY_LINE_OUT_OF_RANGE, input, NUM_LANES bits, per-lane IOD range flag.
REQ-015 SHALL have ports TAP_RD_LANE, input, 4 bits, and TAP_RD_VAL, output, 7 bits, for a combinational tap readback.

Function
REQ-016 SHALL assert REQ_READY only in IDLE; a request is accepted on a cycle with REQ_VALID and REQ_READY both high, and all REQ_* fields are latched then.
REQ-017 SHALL implement states IDLE, LOAD, SETUP, MOVE, GAP and DONE; DONE lasts one cycle, then the FSM returns to IDLE.
REQ-018 SHALL, for REQ_LANE >= NUM_LANES, go directly to DONE with ERR=1 and drive no strobes.
REQ-019 SHALL, for REQ_LOAD=1, pulse DELAY_LINE_LOAD[lane] for exactly one cycle in LOAD, set the tracked tap to LOAD_TAP, then enter DONE with ERR=0; REQ_DIR and REQ_STEPS are ignored.
REQ-020 SHALL, for REQ_STEPS=0 with REQ_LOAD=0, go directly to DONE with ERR=0 and no pulses.
REQ-021 SHALL otherwise drive DELAY_LINE_DIRECTION[lane]=REQ_DIR from SETUP until DONE; all other direction bits are 0.
REQ-022 SHALL pulse DELAY_LINE_MOVE[lane] for one cycle in MOVE, followed by exactly MOVE_GAP GAP cycles.
REQ-023 SHALL sample DELAY_LINE_OUT_OF_RANGE[lane] in the last GAP cycle; if high, enter DONE with ERR=1, abandon remaining steps, and leave the tap unchanged for that step.
REQ-024 SHALL otherwise update the tap by +1 or -1, decrement the remaining step count, and enter MOVE if steps remain, else DONE with ERR=0.
REQ-025 SHALL place MOVE pulses at cycles 2+k*(MOVE_GAP+1), k=0..N-1, and DONE at cycle 2+N*(MOVE_GAP+1), where cycle 0 is the accept cycle.
REQ-026 SHALL hold ERR from DONE until the next accept.
REQ-027 SHALL assert at most one bit across MOVE and LOAD in any cycle.

Reset
REQ-028 SHALL, while SYNC_RST is high, force the FSM to IDLE and drive REQ_READY=0, DONE=0, ERR=0, and all DELAY_LINE_* outputs to 0.
REQ-029 SHALL set every tracked tap to LOAD_TAP on reset; a reset mid-operation abandons the request with no DONE.

Configuration
REQ-030 SHALL, with DDR3_IOD_DLY_TAP_TRACK_EN defined, maintain per-lane taps, stop before pulsing MOVE when REQ_DIR=1 and tap=MAX_TAP or REQ_DIR=0 and tap=0 (entering DONE with ERR=1), and drive TAP_RD_VAL from the tracked tap (0 for an invalid lane).
REQ-031 SHALL, without DDR3_IOD_DLY_TAP_TRACK_EN, omit tap storage and the saturation check, tie TAP_RD_VAL to 0, and rely only on DELAY_LINE_OUT_OF_RANGE for errors.

Structure
REQ-032 SHALL take the FSM state enumeration and the default constants (NUM_LANES, MOVE_GAP, MAX_TAP, LOAD_TAP) from shared package ddr3_iod_dly_pkg.
REQ-033 SHALL implement tap storage, increment/decrement and saturation detection in sub-module ddr3_iod_dly_tap_tracker, instantiated only under DDR3_IOD_DLY_TAP_TRACK_EN.

Verification
REQ-034 SHALL cover: lane 5, DIR=1, STEPS=3, defaults -> MOVE[5] at cycles 2, 6 and 10; DONE at cycle 14 with ERR=0; TAP_RD_VAL(5)=4.
REQ-035 SHALL cover: lane 2, LOAD=1 after prior moves -> LOAD[2] high at cycle 1 only; DONE at cycle 2; TAP_RD_VAL(2)=1.
REQ-036 SHALL cover: lane 0, DIR=1, STEPS=5, OUT_OF_RANGE[0] raised during the 2nd GAP -> two MOVE pulses; DONE with ERR=1; tap=2.
REQ-037 SHALL cover: with the macro defined, lane 1 at tap 1, DIR=0, STEPS=3 -> one MOVE pulse, then DONE with ERR=1 and tap=0.
REQ-038 SHALL cover: REQ_LANE=15 -> DONE at cycle 1 with ERR=1 and no strobes; REQ_STEPS=0 -> DONE with ERR=0.
REQ-039 SHALL cover: SYNC_RST asserted between MOVE pulses -> all outputs 0 the next cycle, no DONE, and REQ_READY=1 after release.
